// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - prescaled countdown controller emitting single-cycle tick/done strobes
module countdown_ctrl #(
   parameter int TICKS_SLOW = 50_000_000,
   parameter int TICKS_FAST = 25_000_000,
   parameter int W          = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         pause,
   input  logic         fast,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         tick,
   output logic         done,
   output logic         busy,
   output logic         expired
);
   localparam int TICKS_MAX = (TICKS_SLOW > TICKS_FAST) ? TICKS_SLOW : TICKS_FAST;
   localparam int PW        = $clog2(TICKS_MAX);
   localparam logic [PW-1:0] TERM_SLOW = PW'(TICKS_SLOW - 1);
   localparam logic [PW-1:0] TERM_FAST = PW'(TICKS_FAST - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

   state_t        state, state_next;
   logic [PW-1:0] pre, pre_next, term;
   logic [W-1:0]  count_next;
   logic          tick_next, done_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pre     <= '0;
         count   <= '0;
         tick    <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= state_next;
         pre     <= pre_next;
         count   <= count_next;
         tick    <= tick_next;
         done    <= done_next;
         busy    <= (state_next == RUN) || (state_next == PAUSED);
         expired <= (state_next == DONE);
      end
   end

   always_comb begin
      state_next = state;
      pre_next   = pre;
      count_next = count;
      tick_next  = 1'b0;
      done_next  = 1'b0;
      term       = fast ? TERM_FAST : TERM_SLOW;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               if (load_val != '0) begin
                  state_next = RUN;
                  count_next = load_val;
                  pre_next   = '0;
               end else begin
                  state_next = DONE;
                  count_next = '0;
                  done_next  = 1'b1;
               end
            end
         end
         RUN, PAUSED: begin
            if (pause) begin
               state_next = PAUSED;
            end else begin
               // The resume cycle counts too, so each paused cycle costs exactly one cycle.
               state_next = RUN;
               if (pre >= term) begin
                  pre_next   = '0;
                  tick_next  = 1'b1;
                  count_next = count - 1'b1;
                  if (count == W'(1)) begin
                     done_next  = 1'b1;
                     state_next = DONE;
                  end
               end else begin
                  pre_next = pre + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed and randomized checks of countdown_ctrl against a reference model
module tb_countdown_ctrl;
   localparam int TS = 8;
   localparam int TF = 4;
   localparam int W  = 4;

   logic         clk = 1'b0;
   logic         rst, start, pause, fast;
   logic [W-1:0] load_val;
   logic [W-1:0] count;
   logic         tick, done, busy, expired;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tick_q[$];

   int m_cnt, m_pre, m_tick, m_done, m_busy, m_exp;

   countdown_ctrl #(.TICKS_SLOW(TS), .TICKS_FAST(TF), .W(W)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .fast(fast),
      .load_val(load_val), .count(count), .tick(tick), .done(done),
      .busy(busy), .expired(expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: an active countdown with a remaining-tick count and cycles elapsed in the current period.
   task automatic model_update();
      int term;
      m_tick = 0;
      m_done = 0;
      if (rst) begin
         m_cnt = 0; m_pre = 0; m_busy = 0; m_exp = 0;
      end else if (!m_busy) begin
         if (start) begin
            if (load_val != 0) begin
               m_busy = 1; m_exp = 0; m_cnt = int'(load_val); m_pre = 0;
            end else begin
               m_exp = 1; m_cnt = 0; m_done = 1;
            end
         end
      end else if (!pause) begin
         term = fast ? TF - 1 : TS - 1;
         if (m_pre >= term) begin
            m_pre = 0;
            m_tick = 1;
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_done = 1; m_busy = 0; m_exp = 1;
            end
         end else begin
            m_pre = m_pre + 1;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
      chk("count", 32'(count), m_cnt);
      chk("tick", 32'(tick), m_tick);
      chk("done", 32'(done), m_done);
      chk("busy", 32'(busy), m_busy);
      chk("expired", 32'(expired), m_exp);
      if (tick === 1'b1) tick_q.push_back(cyc);
      cyc++;
   endtask

   initial begin
      int s, t0;
      bit seen;
      rst = 1'b1; start = 1'b0; pause = 1'b0; fast = 1'b0; load_val = '0;

      // Reset then idle
      repeat (3) cycle();
      rst = 1'b0;
      tick_q.delete();
      repeat (20) cycle();
      chk("idle_no_tick", tick_q.size(), 0);
      chk("idle_count", 32'(count), 0);

      // Slow countdown from 3
      load_val = 4'd3; fast = 1'b0; start = 1'b1;
      s = cyc;
      cycle();
      start = 1'b0;
      chk("slow_load_count", 32'(count), 3);
      tick_q.delete();
      repeat (30) cycle();
      chk("slow_tick_total", tick_q.size(), 3);
      if (tick_q.size() == 3) begin
         chk("slow_first_latency", tick_q[0] - s, 8);
         chk("slow_gap1", tick_q[1] - tick_q[0], 8);
         chk("slow_gap2", tick_q[2] - tick_q[1], 8);
      end
      chk("slow_expired", 32'(expired), 1);
      chk("slow_busy", 32'(busy), 0);

      // Fast switch at prescaler 6, then pause for 5 cycles
      load_val = 4'd2; start = 1'b1;
      cycle();
      start = 1'b0;
      repeat (6) cycle();
      chk("switch_pre_count", 32'(count), 2);
      fast = 1'b1;
      cycle();
      chk("switch_tick", 32'(tick), 1);
      chk("switch_count", 32'(count), 1);
      t0 = cyc - 1;
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("paused_count", 32'(count), 1);
         chk("paused_tick", 32'(tick), 0);
      end
      pause = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle();
         if (tick === 1'b1) seen = 1;
      end
      chk("resume_tick_seen", 32'(seen), 1);
      chk("resume_tick_gap", (cyc - 1) - t0, 9);
      chk("resume_done", 32'(done), 1);
      fast = 1'b0;

      // Zero load from DONE
      load_val = 4'd0; start = 1'b1;
      cycle();
      start = 1'b0;
      chk("zero_done", 32'(done), 1);
      chk("zero_expired", 32'(expired), 1);
      chk("zero_count", 32'(count), 0);
      chk("zero_tick", 32'(tick), 0);
      cycle();
      chk("zero_done_once", 32'(done), 0);

      // Ignored start during RUN, then reset mid-count
      load_val = 4'd4; start = 1'b1;
      cycle();
      start = 1'b0;
      cycle();
      load_val = 4'd5; start = 1'b1;
      cycle();
      start = 1'b0;
      chk("ignored_start_count", 32'(count), 4);
      chk("ignored_start_busy", 32'(busy), 1);
      for (int i = 0; i < 20 && count !== 4'd3; i++) cycle();
      chk("reached_count3", 32'(count), 3);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("midrst_count", 32'(count), 0);
      chk("midrst_flags", {28'd0, tick, done, busy, expired}, 0);
      load_val = 4'd1; start = 1'b1;
      s = cyc;
      cycle();
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle();
         if (tick === 1'b1) seen = 1;
      end
      chk("single_tick_seen", 32'(seen), 1);
      chk("single_tick_latency", (cyc - 1) - s, 8);
      chk("single_done", 32'(done), 1);
      chk("single_count", 32'(count), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         rst   = ($urandom_range(0, 199) == 0);
         start = ($urandom_range(0, 7) == 0);
         pause = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) fast = ~fast;
         load_val = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 2));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
